// File: rtl/best_nonce_collector_if.sv
// Snapshot report channel between best_nonce_collector (master) and the serial interface (slave).
// The master holds valid/nonce/bits_off once a snapshot is presented until the slave acks it.
interface best_nonce_collector_if #(
    parameter int NONCE_WIDTH = 256,
    parameter int SCORE_WIDTH = 10
);
    logic                   report_req;
    logic                   report_valid;
    logic [NONCE_WIDTH-1:0] report_nonce;
    logic [SCORE_WIDTH-1:0] report_bits_off;
    logic                   report_ack;

    modport master (
        input  report_req,
        input  report_ack,
        output report_valid,
        output report_nonce,
        output report_bits_off
    );

    modport slave (
        output report_req,
        output report_ack,
        input  report_valid,
        input  report_nonce,
        input  report_bits_off
    );
endinterface

// File: rtl/best_nonce_collector.sv
// Global best-nonce tracker: round-robin scan of per-core bests, keeps the lowest bits-off score.
// Latency: core sample to best outputs two edges; report valid NUM_CORES+2..2*NUM_CORES+1 cycles after req.
// Backpressure: snapshot frozen in PRESENT until report_ack; requests outside IDLE are dropped.
module best_nonce_collector #(
    parameter int  NUM_CORES   = 4,
    parameter int  NONCE_WIDTH = 256,
    parameter int  SCORE_WIDTH = 10,
    localparam int IDX_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_CORES*NONCE_WIDTH-1:0] core_nonce_i,
    input  logic [NUM_CORES*SCORE_WIDTH-1:0] core_bits_off_i,
    input  logic                             clear_i,
    output logic                             reset_best_nonce_o,
    output logic [NONCE_WIDTH-1:0]           best_nonce_o,
    output logic [SCORE_WIDTH-1:0]           best_bits_off_o,
    output logic [IDX_W-1:0]                 best_core_o,
    output logic                             best_valid_o,
    output logic                             improved_o,
    best_nonce_collector_if.master           report
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {IDLE, ARM, SWEEP, PRESENT} rep_state_t;

    logic [IDX_W-1:0]       scan_idx;
    logic [NONCE_WIDTH-1:0] sel_nonce;
    logic [SCORE_WIDTH-1:0] sel_score;

    logic                   cand_valid;
    logic                   cand_last;
    logic [NONCE_WIDTH-1:0] cand_nonce;
    logic [SCORE_WIDTH-1:0] cand_score;
    logic [IDX_W-1:0]       cand_idx;
    logic                   accept;

    rep_state_t             state, state_nxt;
    logic                   snap_load;
    logic [NONCE_WIDTH-1:0] snap_nonce;
    logic [SCORE_WIDTH-1:0] snap_bits_off;

    always_comb begin
        sel_nonce = '0;
        sel_score = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                sel_nonce = core_nonce_i[k*NONCE_WIDTH +: NONCE_WIDTH];
                sel_score = core_bits_off_i[k*SCORE_WIDTH +: SCORE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i)
            scan_idx <= '0;
        else if (scan_idx == LAST_IDX)
            scan_idx <= '0;
        else
            scan_idx <= scan_idx + 1'b1;
    end

    // Stage 1: clear drops whatever is sampled on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cand_valid <= 1'b0;
            cand_last  <= 1'b0;
        end else begin
            cand_valid <= 1'b1;
            cand_last  <= (scan_idx == LAST_IDX);
        end
    end

    always_ff @(posedge clk_i) begin
        cand_nonce <= sel_nonce;
        cand_score <= sel_score;
        cand_idx   <= scan_idx;
    end

    // Strict compare: ties keep the incumbent and an all-ones score can never win.
    assign accept = cand_valid && (cand_score < best_bits_off_o);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            best_bits_off_o <= '1;
            best_nonce_o    <= '0;
            best_core_o     <= '0;
            best_valid_o    <= 1'b0;
            improved_o      <= 1'b0;
        end else begin
            improved_o <= accept;
            if (accept) begin
                best_bits_off_o <= cand_score;
                best_nonce_o    <= cand_nonce;
                best_core_o     <= cand_idx;
                best_valid_o    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            reset_best_nonce_o <= 1'b0;
        else
            reset_best_nonce_o <= clear_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ARM leaves on the edge that samples core 0, so the whole sweep postdates the request.
    always_comb begin
        state_nxt = state;
        snap_load = 1'b0;
        case (state)
            IDLE:    if (report.report_req) state_nxt = ARM;
            ARM:     if (scan_idx == '0) state_nxt = SWEEP;
            SWEEP: begin
                if (cand_valid && cand_last) begin
                    state_nxt = PRESENT;
                    snap_load = 1'b1;
                end
            end
            PRESENT: if (report.report_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear_i) begin
            state_nxt = IDLE;
            snap_load = 1'b0;
        end
    end

    // Snapshot takes the post-update best, so the final sweep candidate is included.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_nonce    <= '0;
            snap_bits_off <= '1;
        end else if (snap_load) begin
            snap_nonce    <= accept ? cand_nonce : best_nonce_o;
            snap_bits_off <= accept ? cand_score : best_bits_off_o;
        end
    end

    assign report.report_valid    = (state == PRESENT);
    assign report.report_nonce    = snap_nonce;
    assign report.report_bits_off = snap_bits_off;

endmodule
